// File: rtl/ctrl_boot_loader_if.sv
// ctrl_boot_loader_if: SRAM and FLASH bus bundle driven by the boot loader.
// master: drives the SRAM address, strobes and write data, and the FLASH address, strobes and write data.
// master: receives the SRAM read data and the FLASH read data.
// slave: the memory side, with every direction reversed.
interface ctrl_boot_loader_if;
    logic [17:0] sram_adr;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [15:0] sram_dat_w, sram_dat_r;
    logic [21:0] fl_adr;
    logic        fl_ce_n, fl_we_n, fl_oe_n, fl_rst_n;
    logic [7:0]  fl_dat_w, fl_dat_r;
    modport master (
        output sram_adr, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dat_w,
        output fl_adr, fl_ce_n, fl_we_n, fl_oe_n, fl_rst_n, fl_dat_w,
        input  sram_dat_r, fl_dat_r
    );
    modport slave (
        input  sram_adr, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n, sram_dat_w,
        input  fl_adr, fl_ce_n, fl_we_n, fl_oe_n, fl_rst_n, fl_dat_w,
        output sram_dat_r, fl_dat_r
    );
endinterface

// File: rtl/ctrl_boot_loader.sv
// ctrl_boot_loader: copies a boot image from 8-bit FLASH into 16-bit SRAM, then reports the result over UART.
// clk_in/clk_out: the system clock and its pass-through copy. rst_ext: synchronous active-high reset.
// rst_out: held high until the copy is done. rst_minimig: released after boot unless it is held or an error occurred.
// boot_sel: selects the FLASH image base. ctrl_cfg: bit0 skips verify, bit1 holds rst_minimig.
// rom_status/ram_status: a FLASH or SRAM access is in progress. reg_status: one-cycle pulse when the copy is done.
// ctrl_status: {running, boot_sel, error, done}. mem: the SRAM and FLASH buses.
// uart_txd: sends 'O' or 'E' as 8N1. spi_*: parked.
module ctrl_boot_loader #(
    parameter int unsigned BOOT_WORDS = 4096,
    parameter logic [21:0] FL_BASE0   = 22'h000000,
    parameter logic [21:0] FL_BASE1   = 22'h200000,
    parameter int unsigned FL_WAIT    = 4,
    parameter int unsigned SR_WAIT    = 2,
    parameter int unsigned UART_DIV   = 434
) (
    input  logic                clk_in,
    input  logic                rst_ext,
    output logic                clk_out,
    output logic                rst_out,
    output logic                rst_minimig,
    input  logic                boot_sel,
    input  logic [3:0]          ctrl_cfg,
    output logic                rom_status,
    output logic                ram_status,
    output logic                reg_status,
    output logic [3:0]          ctrl_status,
    ctrl_boot_loader_if.master  mem,
    output logic                uart_txd,
    output logic                spi_cs_n,
    output logic                spi_clk,
    output logic                spi_do,
    input  logic                spi_di
);
    typedef enum logic [3:0] {IDLE, FRD_HI, FRD_LO, SWR, SWH, SRD, DONE, TX, END} state_t;
    localparam logic [15:0] FL_LAST  = 16'(FL_WAIT - 1);
    localparam logic [15:0] SR_LAST  = 16'(SR_WAIT - 1);
    localparam logic [15:0] DIV_LAST = 16'(UART_DIV - 1);
    localparam logic [18:0] I_LAST   = 19'(BOOT_WORDS - 1);
    state_t      state, state_n;
    logic [18:0] i;
    logic [15:0] cnt, word;
    logic [3:0]  bit_idx;
    logic        bsel, err, done, fl_last, sr_last, tick, word_end, last_word, unused_ok;
    logic [9:0]  frame;
    logic [21:0] base;
    assign fl_last   = cnt == FL_LAST;
    assign sr_last   = cnt == SR_LAST;
    assign tick      = state == TX && cnt == DIV_LAST;
    assign last_word = i == I_LAST;
    assign word_end  = (state == SWH && ctrl_cfg[0]) || (state == SRD && sr_last);
    assign done      = state inside {DONE, TX, END};
    assign base      = bsel ? FL_BASE1 : FL_BASE0;
    assign frame     = {1'b1, err ? 8'h45 : 8'h4F, 1'b0};
    always_ff @(posedge clk_in) begin
        if (rst_ext) begin
            state       <= IDLE;
            i           <= '0;
            cnt         <= '0;
            word        <= '0;
            bit_idx     <= '0;
            bsel        <= 1'b0;
            err         <= 1'b0;
            rst_minimig <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || tick) ? '0 : cnt + 16'd1;
            if (state == IDLE) bsel <= boot_sel;
            if (state == FRD_HI && fl_last) word[15:8] <= mem.fl_dat_r;
            if (state == FRD_LO && fl_last) word[7:0] <= mem.fl_dat_r;
            if (state == SRD && sr_last && mem.sram_dat_r != word) err <= 1'b1;
            if (word_end) i <= i + 19'd1;
            if (tick) bit_idx <= bit_idx + 4'd1;
            if (done) rst_minimig <= ctrl_cfg[1] | err;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FRD_HI;
            FRD_HI:  state_n = fl_last ? FRD_LO : FRD_HI;
            FRD_LO:  state_n = fl_last ? SWR : FRD_LO;
            SWR:     state_n = sr_last ? SWH : SWR;
            SWH:     state_n = ctrl_cfg[0] ? (last_word ? DONE : FRD_HI) : SRD;
            SRD:     state_n = sr_last ? (last_word ? DONE : FRD_HI) : SRD;
            DONE:    state_n = TX;
            TX:      state_n = (tick && bit_idx == 4'd9) ? END : TX;
            default: state_n = END;
        endcase
    end
    assign rom_status     = state == FRD_HI || state == FRD_LO;
    assign ram_status     = state == SWR || state == SWH || state == SRD;
    assign reg_status     = state == DONE;
    assign ctrl_status    = {rom_status | ram_status, bsel, err, done};
    assign rst_out        = rst_ext | ~done;
    assign clk_out        = clk_in;
    // 2i is even, so the low-byte address base+2i+1 is formed by setting bit 0 before the add
    assign mem.fl_adr     = rom_status ? base + {2'b00, i, state == FRD_LO} : '0;
    assign mem.fl_ce_n    = ~rom_status;
    assign mem.fl_oe_n    = ~rom_status;
    assign mem.fl_we_n    = 1'b1;
    assign mem.fl_rst_n   = state != IDLE;
    assign mem.fl_dat_w   = '0;
    assign mem.sram_adr   = ram_status ? i[17:0] : '0;
    assign mem.sram_dat_w = ram_status ? word : '0;
    assign mem.sram_ce_n  = ~ram_status;
    assign mem.sram_we_n  = state != SWR;
    assign mem.sram_oe_n  = state != SRD;
    assign mem.sram_ub_n  = state != SWR;
    assign mem.sram_lb_n  = state != SWR;
    assign uart_txd       = state == TX ? frame[bit_idx] : 1'b1;
    assign spi_cs_n       = 1'b1;
    assign spi_clk        = 1'b0;
    assign spi_do         = 1'b1;
    assign unused_ok      = &{1'b0, spi_di, ctrl_cfg[3:2]};
endmodule

// File: tb/tb_ctrl_boot_loader.sv
// tb_ctrl_boot_loader: randomized boot images checked against a memory-level model of the copy.
module tb_ctrl_boot_loader;
    localparam int NW = 16, FW = 4, SW = 2, DIV = 16;
    logic clk = 1'b0, rst_ext = 1'b1, boot_sel = 1'b0, spi_di = 1'b0;
    logic [3:0] ctrl_cfg = 4'd0;
    logic clk_out, rst_out, rst_minimig, rom_status, ram_status, reg_status, uart_txd, spi_cs_n, spi_clk, spi_do;
    logic [3:0] ctrl_status;
    logic [7:0] fl0 [64];
    logic [7:0] fl1 [64];
    logic [15:0] sram [64];
    logic stuck = 1'b0;
    int checks = 0, errors = 0, viol = 0, oe_cnt = 0;
    ctrl_boot_loader_if mem();
    ctrl_boot_loader #(.BOOT_WORDS(NW), .FL_WAIT(FW), .SR_WAIT(SW), .UART_DIV(DIV)) dut (
        .clk_in(clk), .rst_ext(rst_ext), .clk_out(clk_out), .rst_out(rst_out), .rst_minimig(rst_minimig),
        .boot_sel(boot_sel), .ctrl_cfg(ctrl_cfg), .rom_status(rom_status), .ram_status(ram_status),
        .reg_status(reg_status), .ctrl_status(ctrl_status), .mem(mem), .uart_txd(uart_txd),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_do(spi_do), .spi_di(spi_di)
    );
    always #5 clk = ~clk;
    assign mem.fl_dat_r = (mem.fl_adr < 22'd64) ? fl0[mem.fl_adr[5:0]] :
                          (mem.fl_adr[21:6] == 16'h8000) ? fl1[mem.fl_adr[5:0]] : 8'hFF;
    assign mem.sram_dat_r = sram[mem.sram_adr[5:0]] & ((stuck && mem.sram_adr == 18'd2) ? 16'hFFF7 : 16'hFFFF);
    always @(negedge clk) begin
        if (!mem.sram_ce_n && !mem.sram_we_n) sram[mem.sram_adr[5:0]] <= mem.sram_dat_w;
        if (!mem.sram_oe_n) oe_cnt <= oe_cnt + 1;
        if ((rom_status && mem.sram_ce_n !== 1'b1) || mem.fl_we_n !== 1'b1 || (!mem.sram_we_n && mem.sram_oe_n !== 1'b1) ||
            spi_cs_n !== 1'b1 || spi_clk !== 1'b0 || spi_do !== 1'b1)
            viol <= viol + 1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] exp_word(input int w, input logic bs);
        return bs ? {fl1[2*w], fl1[2*w+1]} : {fl0[2*w], fl0[2*w+1]};
    endfunction
    task automatic fill();
        for (int k = 0; k < 64; k++) begin
            fl0[k] = 8'($urandom);
            fl1[k] = 8'($urandom);
        end
    endtask
    task automatic check_reset();
        chk("rst_strobes", {24'd0, mem.fl_ce_n, mem.fl_we_n, mem.fl_oe_n, mem.sram_ce_n, mem.sram_we_n,
            mem.sram_oe_n, mem.sram_ub_n, mem.sram_lb_n}, 32'hFF);
        chk("rst_fl_rst_n", {31'd0, mem.fl_rst_n}, 32'd0);
        chk("rst_fl_adr", {10'd0, mem.fl_adr}, 32'd0);
        chk("rst_sram_adr_dat", {mem.sram_adr[15:0], mem.sram_dat_w}, 32'd0);
        chk("rst_status", {25'd0, rom_status, ram_status, reg_status, ctrl_status}, 32'd0);
        chk("rst_lines", {29'd0, uart_txd, rst_out, rst_minimig}, 32'd7);
    endtask
    task automatic do_reset();
        rst_ext = 1'b1;
        step(2);
        check_reset();
    endtask
    task automatic run(input logic bs, input logic [3:0] cfg);
        int cyc, lat, oe0, v0;
        logic verify, err_exp;
        logic [15:0] ew;
        logic [7:0] rx;
        verify = ~cfg[0];
        ew = exp_word(2, bs);
        err_exp = verify && stuck && ew[3];
        lat = 2*FW + SW + 1 + (verify ? SW : 0);
        boot_sel = bs;
        ctrl_cfg = cfg;
        oe0 = oe_cnt;
        v0 = viol;
        rst_ext = 1'b0;
        cyc = 0;
        while (cyc < 2000) begin
            step(1);
            cyc++;
            if (cyc == 1) chk("running_bsel", {30'd0, ctrl_status[3:2]}, {30'd0, 1'b1, bs});
            if (ctrl_status[0]) break;
        end
        if (!ctrl_status[0]) begin
            chk("done_timeout", 32'd0, 32'd1);
            return;
        end
        chk("done_latency", cyc, NW*lat + 1);
        chk("done_status", {28'd0, ctrl_status}, {28'd0, 1'b0, bs, err_exp, 1'b1});
        chk("done_lines", {28'd0, reg_status, rst_out, uart_txd, rst_minimig}, 32'b1011);
        for (int w = 0; w < NW; w++) chk($sformatf("sram_word%0d", w), {16'd0, sram[w]}, {16'd0, exp_word(w, bs)});
        step(1);
        chk("start_bit", {29'd0, reg_status, uart_txd, rst_minimig}, {29'd0, 1'b0, 1'b0, cfg[1] | err_exp});
        step(DIV/2);
        chk("start_mid", {31'd0, uart_txd}, 32'd0);
        for (int b = 0; b < 8; b++) begin
            step(DIV);
            rx[b] = uart_txd;
        end
        chk("uart_byte", {24'd0, rx}, err_exp ? 32'h45 : 32'h4F);
        step(DIV);
        chk("stop_bit", {31'd0, uart_txd}, 32'd1);
        step(DIV);
        chk("end_hold", {27'd0, uart_txd, ctrl_status}, {27'd0, 1'b1, 1'b0, bs, err_exp, 1'b1});
        chk("oe_activity", {31'd0, oe_cnt != oe0}, {31'd0, verify});
        chk("strobe_rules", viol - v0, 32'd0);
    endtask
    initial begin
        int cyc;
        step(3);
        check_reset();
        fill();
        run(1'b0, 4'b0000);
        fill();
        fl1[0] = 8'hA5;
        fl1[1] = 8'h5A;
        do_reset();
        run(1'b1, 4'b0000);
        chk("bsel1_word0", {16'd0, sram[0]}, 32'hA55A);
        fill();
        fl0[5] = fl0[5] | 8'h08;
        stuck = 1'b1;
        do_reset();
        run(1'b0, 4'b0000);
        stuck = 1'b0;
        fill();
        do_reset();
        run(1'b0, 4'b0011);
        fill();
        do_reset();
        rst_ext = 1'b0;
        boot_sel = 1'b0;
        ctrl_cfg = 4'b0000;
        cyc = 0;
        while (cyc < 1000 && !(ram_status && mem.sram_adr == 18'd7)) begin
            step(1);
            cyc++;
        end
        chk("reach_word7", {31'd0, ram_status}, 32'd1);
        rst_ext = 1'b1;
        step(1);
        check_reset();
        fill();
        run(1'b0, 4'b0000);
        for (int t = 0; t < 2; t++) begin
            fill();
            do_reset();
            run(1'($urandom), 4'($urandom_range(0, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
